// File: rtl/vga_pkg.sv
// Shared timing constants, mode encoding and colour helpers
// for the VGA pixel fetch pipeline.
package vga_pkg;

    localparam int H_LAST      = 800;
    localparam int V_LAST      = 528;
    localparam int H_ACT_START = 112;
    localparam int V_ACT_START = 13;
    localparam int H_ACT       = 640;
    localparam int V_ACT       = 480;
    localparam int IMG_SIZE    = 256;
    localparam int BAR_W       = 80;

    typedef enum logic [1:0] {
        GRAY   = 2'd0,
        RGB332 = 2'd1,
        BARS   = 2'd2,
        BLACK  = 2'd3
    } mode_e;

    typedef struct packed {
        logic       act;
        logic       img;
        logic [2:0] bar;
        mode_e      mode;
    } pix_flags_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic rgb_t rgb332(input logic [7:0] d);
        rgb_t c;
        c.r = {d[7:5], d[7:5], d[7:6]};
        c.g = {d[4:2], d[4:2], d[4:3]};
        c.b = {4{d[1:0]}};
        return c;
    endfunction

    // ha is the column relative to the first active column
    function automatic logic [2:0] bar_of(input logic [10:0] ha);
        logic [2:0] k;
        k = '0;
        for (int i = 1; i < 8; i++) begin
            if (ha >= 11'(i * BAR_W)) k = 3'(i);
        end
        return k;
    endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Bundle between the window/address logic and the
// flag/data delay pipeline.
interface vga_pixel_fetch_if;
    import vga_pkg::*;

    pix_flags_t flags;
    logic [7:0] mem_data;
    logic [7:0] border;
    rgb_t       rgb;

    modport master (
        output flags,
        output mem_data,
        output border,
        input  rgb
    );

    modport slave (
        input  flags,
        input  mem_data,
        input  border,
        output rgb
    );

endinterface

// File: rtl/vga_fetch_pipe.sv
// Three-stage delay of pixel flags, aligned with the RAM read
// latency, ending in the registered colour.
module vga_fetch_pipe
    import vga_pkg::*;
(
    input logic               clk,
    input logic               rst,
    vga_pixel_fetch_if.slave  bus
);

    pix_flags_t s1_q, s1_d;
    pix_flags_t s2_q, s2_d;
    rgb_t       rgb_q, rgb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            rgb_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            rgb_q <= rgb_d;
        end
    end

    // RAM data for the stage-2 pixel is live on mem_data this cycle
    always_comb begin
        s1_d  = bus.flags;
        s2_d  = s1_q;
        rgb_d = '0;
        if (s2_q.act) begin
            unique case (s2_q.mode)
                GRAY: begin
                    rgb_d = s2_q.img ? {3{bus.mem_data}}
                                     : {3{bus.border}};
                end
                RGB332: begin
                    rgb_d = s2_q.img ? rgb332(bus.mem_data)
                                     : {3{bus.border}};
                end
                BARS: begin
                    rgb_d = {{8{s2_q.bar[2]}},
                             {8{s2_q.bar[1]}},
                             {8{s2_q.bar[0]}}};
                end
                BLACK: rgb_d = '0;
            endcase
        end
    end

    assign bus.rgb = rgb_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer pixel fetch: window decode, RAM addressing,
// double-buffer swap and mode latching at frame boundary.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int H_ACT_START = vga_pkg::H_ACT_START,
    parameter int V_ACT_START = vga_pkg::V_ACT_START,
    parameter int X_OFF       = 192,
    parameter int Y_OFF       = 112,
    parameter int H_LAST      = vga_pkg::H_LAST,
    parameter int V_LAST      = vga_pkg::V_LAST
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [9:0]  H_Cont,
    input  logic [9:0]  V_Cont,
    input  logic [1:0]  iMode,
    input  logic [7:0]  iBorder,
    input  logic        iSwapReq,
    output logic        oSwapAck,
    output logic [16:0] oMemAddr,
    output logic        oMemEn,
    input  logic [7:0]  iMemData,
    output logic        oFrameStart,
    output logic [7:0]  oRed,
    output logic [7:0]  oGreen,
    output logic [7:0]  oBlue
);

    localparam logic [10:0] HA0 = 11'(H_ACT_START);
    localparam logic [10:0] HA1 = 11'(H_ACT_START + H_ACT);
    localparam logic [10:0] HI0 = 11'(H_ACT_START + X_OFF);
    localparam logic [10:0] HI1 = 11'(H_ACT_START + X_OFF + IMG_SIZE);
    localparam logic [10:0] HLT = 11'(H_LAST);
    localparam logic [9:0]  VA0 = 10'(V_ACT_START);
    localparam logic [9:0]  VA1 = 10'(V_ACT_START + V_ACT);
    localparam logic [9:0]  VI0 = 10'(V_ACT_START + Y_OFF);
    localparam logic [9:0]  VI1 = 10'(V_ACT_START + Y_OFF + IMG_SIZE);

    logic [10:0] hl, ha, hx;
    logic [9:0]  vy;
    logic        act, img, frame_edge;
    pix_flags_t  flags;

    mode_e       mode_q, mode_d;
    logic        buf_q, buf_d;
    logic [16:0] addr_q, addr_d;
    logic        en_q, en_d;
    logic        fs_q, fs_d;
    logic        ack_q, ack_d;

    // hl is kept one bit wider so lookahead past H_LAST never wraps
    always_comb begin
        hl = {1'b0, H_Cont} + 11'(LATENCY);
        ha = hl - HA0;
        hx = hl - HI0;
        vy = V_Cont - VI0;
        act = (hl >= HA0) && (hl < HA1) && (hl <= HLT)
           && (V_Cont >= VA0) && (V_Cont < VA1);
        img = (hl >= HI0) && (hl < HI1) && (hl <= HLT)
           && (V_Cont >= VI0) && (V_Cont < VI1);
        frame_edge = (H_Cont == 10'(H_LAST))
                  && (V_Cont == 10'(V_LAST));
        flags.act  = act;
        flags.img  = img;
        flags.bar  = bar_of(ha);
        flags.mode = mode_q;
    end

    always_comb begin
        mode_d = mode_q;
        buf_d  = buf_q;
        fs_d   = frame_edge;
        ack_d  = frame_edge && iSwapReq;
        if (frame_edge) begin
            mode_d = mode_e'(iMode);
            buf_d  = buf_q ^ iSwapReq;
        end
        addr_d = {buf_q, vy[7:0], hx[7:0]};
        en_d   = img && ((mode_q == GRAY) || (mode_q == RGB332));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mode_q <= GRAY;
            buf_q  <= 1'b0;
            addr_q <= '0;
            en_q   <= 1'b0;
            fs_q   <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            buf_q  <= buf_d;
            addr_q <= addr_d;
            en_q   <= en_d;
            fs_q   <= fs_d;
            ack_q  <= ack_d;
        end
    end

    vga_pixel_fetch_if pix_bus ();

    assign pix_bus.flags    = flags;
    assign pix_bus.mem_data = iMemData;
    assign pix_bus.border   = iBorder;

    vga_fetch_pipe u_pipe (
        .clk (iCLK),
        .rst (iRST),
        .bus (pix_bus)
    );

    assign oRed        = pix_bus.rgb.r;
    assign oGreen      = pix_bus.rgb.g;
    assign oBlue       = pix_bus.rgb.b;
    assign oMemAddr    = addr_q;
    assign oMemEn      = en_q;
    assign oFrameStart = fs_q;
    assign oSwapAck    = ack_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a one-cycle
// synchronous RAM model returning a programmable word.
module tb_vga_pixel_fetch;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [9:0]  H_Cont = '0;
    logic [9:0]  V_Cont = '0;
    logic [1:0]  iMode = 2'd0;
    logic [7:0]  iBorder = 8'h11;
    logic        iSwapReq = 1'b0;
    logic        oSwapAck;
    logic [16:0] oMemAddr;
    logic        oMemEn;
    logic [7:0]  iMemData = '0;
    logic        oFrameStart;
    logic [7:0]  oRed, oGreen, oBlue;

    logic [7:0]  ram_word = '0;
    int          total = 0;
    int          bad = 0;

    vga_pixel_fetch dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .H_Cont      (H_Cont),
        .V_Cont      (V_Cont),
        .iMode       (iMode),
        .iBorder     (iBorder),
        .iSwapReq    (iSwapReq),
        .oSwapAck    (oSwapAck),
        .oMemAddr    (oMemAddr),
        .oMemEn      (oMemEn),
        .iMemData    (iMemData),
        .oFrameStart (oFrameStart),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue)
    );

    always #5 iCLK = ~iCLK;

    // synchronous RAM: data appears the cycle after oMemEn
    always @(posedge iCLK) begin
        if (oMemEn) iMemData <= ram_word;
    end

    task automatic chk(input string tag,
                       input logic [23:0] obs,
                       input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input string tag,
                           input logic [23:0] exp);
        chk(tag, {oRed, oGreen, oBlue}, exp);
    endtask

    // present one counter value, then observe #1 after the edge
    task automatic clk1(input logic [9:0] h,
                        input logic [9:0] v);
        H_Cont = h;
        V_Cont = v;
        @(posedge iCLK);
        #1;
    endtask

    // colour for sample h shows up after three edges
    task automatic px(input string tag,
                      input logic [9:0] h,
                      input logic [9:0] v,
                      input logic [23:0] exp);
        clk1(h, v);
        clk1(h + 10'd1, v);
        clk1(h + 10'd2, v);
        chk_rgb(tag, exp);
    endtask

    initial begin
        // reset state
        clk1(10'd0, 10'd0);
        clk1(10'd0, 10'd0);
        chk_rgb("rst_rgb", 24'h000000);
        chk("rst_en", 24'(oMemEn), 24'h0);
        chk("rst_addr", 24'(oMemAddr), 24'h0);
        chk("rst_fs", 24'(oFrameStart), 24'h0);
        chk("rst_ack", 24'(oSwapAck), 24'h0);
        iRST = 1'b0;

        // grayscale, first image pixel
        ram_word = 8'h80;
        clk1(10'd301, 10'd125);
        chk("g_addr0", 24'(oMemAddr), 24'h00000);
        chk("g_en0", 24'(oMemEn), 24'h1);
        clk1(10'd302, 10'd125);
        chk("g_addr1", 24'(oMemAddr), 24'h00001);
        clk1(10'd303, 10'd125);
        chk_rgb("g_pix304", 24'h808080);
        clk1(10'd310, 10'd130);
        chk("g_addr_rc", 24'(oMemAddr), 24'h00509);

        // window edges in grayscale
        px("g_border_l", 10'd197, 10'd125, 24'h111111);
        px("g_blank_l", 10'd97, 10'd125, 24'h000000);
        px("g_border_v", 10'd301, 10'd50, 24'h111111);
        chk("g_en_v", 24'(oMemEn), 24'h0);
        px("g_img_last", 10'd556, 10'd125, 24'h808080);
        px("g_img_past", 10'd557, 10'd125, 24'h111111);
        px("g_act_last", 10'd748, 10'd125, 24'h111111);
        px("g_act_past", 10'd749, 10'd125, 24'h000000);

        // mode change waits for the frame boundary
        iMode = 2'd1;
        ram_word = 8'hE0;
        px("m1_pre", 10'd301, 10'd125, 24'hE0E0E0);
        clk1(10'd800, 10'd528);
        chk("fs_pulse", 24'(oFrameStart), 24'h1);
        chk("ack_noreq", 24'(oSwapAck), 24'h0);
        clk1(10'd0, 10'd0);
        chk("fs_drop", 24'(oFrameStart), 24'h0);
        px("m1_red", 10'd301, 10'd125, 24'hFF0000);
        ram_word = 8'h03;
        px("m1_blue", 10'd301, 10'd125, 24'h0000FF);
        ram_word = 8'h6D;
        px("m1_mix", 10'd301, 10'd125, 24'h6D6D55);

        // colour bars with a buffer swap
        iMode = 2'd2;
        iSwapReq = 1'b1;
        clk1(10'd800, 10'd528);
        chk("sw_fs", 24'(oFrameStart), 24'h1);
        chk("sw_ack", 24'(oSwapAck), 24'h1);
        iSwapReq = 1'b0;
        clk1(10'd301, 10'd125);
        chk("sw_addr", 24'(oMemAddr), 24'h10000);
        chk("sw_ack_drop", 24'(oSwapAck), 24'h0);
        chk("b_en_img", 24'(oMemEn), 24'h0);
        clk1(10'd192, 10'd200);
        chk("b_en192", 24'(oMemEn), 24'h0);
        clk1(10'd193, 10'd200);
        chk("b_en193", 24'(oMemEn), 24'h0);
        clk1(10'd194, 10'd200);
        chk("b_en194", 24'(oMemEn), 24'h0);
        chk_rgb("b_bar1_192", 24'h0000FF);
        clk1(10'd195, 10'd200);
        chk_rgb("b_bar1_193", 24'h0000FF);
        px("b_bar0_edge", 10'd188, 10'd200, 24'h000000);
        px("b_bar1_edge", 10'd189, 10'd200, 24'h0000FF);
        px("b_bar5", 10'd509, 10'd200, 24'hFF00FF);
        px("b_bar6", 10'd589, 10'd200, 24'hFFFF00);
        px("b_bar7", 10'd669, 10'd200, 24'hFFFFFF);
        px("b_blank", 10'd749, 10'd200, 24'h000000);

        // black mode only after the boundary
        iMode = 2'd3;
        px("k_pre", 10'd192, 10'd200, 24'h0000FF);
        clk1(10'd800, 10'd528);
        px("k_bar", 10'd192, 10'd200, 24'h000000);
        ram_word = 8'h77;
        clk1(10'd301, 10'd125);
        chk("k_en", 24'(oMemEn), 24'h0);
        px("k_img", 10'd301, 10'd125, 24'h000000);
        px("k_border", 10'd197, 10'd125, 24'h000000);

        // reset with pixels in flight
        ram_word = 8'h5A;
        clk1(10'd301, 10'd125);
        clk1(10'd302, 10'd125);
        iRST = 1'b1;
        clk1(10'd303, 10'd125);
        chk_rgb("r_rgb", 24'h000000);
        chk("r_en", 24'(oMemEn), 24'h0);
        chk("r_addr", 24'(oMemAddr), 24'h0);
        iRST = 1'b0;
        clk1(10'd310, 10'd130);
        chk("r_addr_buf0", 24'(oMemAddr), 24'h00509);
        chk("r_en_gray", 24'(oMemEn), 24'h1);
        chk_rgb("r_flush1", 24'h000000);
        clk1(10'd311, 10'd130);
        chk_rgb("r_flush2", 24'h000000);
        clk1(10'd312, 10'd130);
        chk_rgb("r_resume", 24'h5A5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
